// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: decoded instruction in, bypass sources, registered payload out.
// The master side is the surrounding pipeline; the slave side is the stage itself.
interface id_ex_stage_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned CNT_W  = 16
);
    // Decoded instruction from ID plus register file read data
    logic              id_valid;
    logic              id_ready;
    logic [WIDTH-1:0]  id_pc;
    logic [4:0]        id_rs1_addr;
    logic [4:0]        id_rs2_addr;
    logic              id_uses_rs1;
    logic              id_uses_rs2;
    logic [WIDTH-1:0]  id_rs1_data;
    logic [WIDTH-1:0]  id_rs2_data;
    logic [4:0]        id_rd_addr;
    logic [WIDTH-1:0]  id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_mem_read;
    logic              id_reg_write;
    logic              flush;

    // Bypass sources from the later stages
    logic              mem_reg_write;
    logic              mem_mem_read;
    logic [4:0]        mem_rd_addr;
    logic [WIDTH-1:0]  mem_result;
    logic              wb_reg_write;
    logic [4:0]        wb_rd_addr;
    logic [WIDTH-1:0]  wb_data;

    // Registered payload toward EX
    logic              ex_ready;
    logic              ex_valid;
    logic [WIDTH-1:0]  ex_pc;
    logic [WIDTH-1:0]  ex_rs1_val;
    logic [WIDTH-1:0]  ex_rs2_val;
    logic [WIDTH-1:0]  ex_imm;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [4:0]        ex_rd_addr;
    logic              ex_mem_read;
    logic              ex_reg_write;

    // Stall statistics
    logic              stall_cnt_clr;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
               id_rs1_data, id_rs2_data, id_rd_addr, id_imm, id_ctrl, id_mem_read,
               id_reg_write, flush, mem_reg_write, mem_mem_read, mem_rd_addr, mem_result,
               wb_reg_write, wb_rd_addr, wb_data, ex_ready, stall_cnt_clr,
        input  id_ready, ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_ctrl,
               ex_rd_addr, ex_mem_read, ex_reg_write, stall_count
    );

    modport slave (
        input  id_valid, id_pc, id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
               id_rs1_data, id_rs2_data, id_rd_addr, id_imm, id_ctrl, id_mem_read,
               id_reg_write, flush, mem_reg_write, mem_mem_read, mem_rd_addr, mem_result,
               wb_reg_write, wb_rd_addr, wb_data, ex_ready, stall_cnt_clr,
        output id_ready, ex_valid, ex_pc, ex_rs1_val, ex_rs2_val, ex_imm, ex_ctrl,
               ex_rd_addr, ex_mem_read, ex_reg_write, stall_count
    );
endinterface

// File: rtl/id_ex_stage.sv
// Operand resolve and ID/EX pipeline register: bypasses MEM/WB results onto the register
// file operands, holds back instructions that depend on an in-flight load, and registers
// the resolved instruction toward EX behind a valid/ready handshake.
module id_ex_stage #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned CNT_W  = 16
) (
    input logic          clk,
    input logic          rst_n,
    id_ex_stage_if.slave bus
);

    typedef struct packed {
        logic [WIDTH-1:0]  pc;
        logic [WIDTH-1:0]  rs1_val;
        logic [WIDTH-1:0]  rs2_val;
        logic [WIDTH-1:0]  imm;
        logic [CTRL_W-1:0] ctrl;
        logic [4:0]        rd_addr;
        logic              mem_read;
        logic              reg_write;
    } payload_t;

    payload_t         ex_q, ex_d;
    logic             ex_valid_q, ex_valid_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic [WIDTH-1:0] rs1_fwd, rs2_fwd;
    logic             ex_load, mem_load;
    logic             hazard_rs1, hazard_rs2, hazard;
    logic             load_en;

    // Youngest producer wins; WB also covers the register file's write-then-read window.
    function automatic logic [WIDTH-1:0] resolve_operand(
        input logic [4:0]       addr,
        input logic [WIDTH-1:0] rf_data,
        input logic             mem_we,
        input logic [4:0]       mem_rd,
        input logic [WIDTH-1:0] mem_val,
        input logic             wb_we,
        input logic [4:0]       wb_rd,
        input logic [WIDTH-1:0] wb_val
    );
        logic [WIDTH-1:0] val;
        if (addr == 5'd0) begin
            val = '0;
        end else if (mem_we && (mem_rd == addr)) begin
            val = mem_val;
        end else if (wb_we && (wb_rd == addr)) begin
            val = wb_val;
        end else begin
            val = rf_data;
        end
        return val;
    endfunction

    // Bypass mux for both source operands
    always_comb begin
        rs1_fwd = resolve_operand(bus.id_rs1_addr, bus.id_rs1_data,
                                  bus.mem_reg_write, bus.mem_rd_addr, bus.mem_result,
                                  bus.wb_reg_write, bus.wb_rd_addr, bus.wb_data);
        rs2_fwd = resolve_operand(bus.id_rs2_addr, bus.id_rs2_data,
                                  bus.mem_reg_write, bus.mem_rd_addr, bus.mem_result,
                                  bus.wb_reg_write, bus.wb_rd_addr, bus.wb_data);
    end

    // Load-use detection: a load in EX or MEM has no data yet for a dependent consumer
    always_comb begin
        ex_load    = ex_valid_q && ex_q.mem_read && ex_q.reg_write;
        mem_load   = bus.mem_reg_write && bus.mem_mem_read;
        hazard_rs1 = bus.id_uses_rs1 && (bus.id_rs1_addr != 5'd0) &&
                     ((ex_load && (ex_q.rd_addr == bus.id_rs1_addr)) ||
                      (mem_load && (bus.mem_rd_addr == bus.id_rs1_addr)));
        hazard_rs2 = bus.id_uses_rs2 && (bus.id_rs2_addr != 5'd0) &&
                     ((ex_load && (ex_q.rd_addr == bus.id_rs2_addr)) ||
                      (mem_load && (bus.mem_rd_addr == bus.id_rs2_addr)));
        hazard     = hazard_rs1 || hazard_rs2;
        load_en    = !ex_valid_q || bus.ex_ready;
    end

    // Next-state for the pipeline register: flush, capture, bubble, or hold
    always_comb begin
        ex_valid_d = ex_valid_q;
        ex_d       = ex_q;
        if (bus.flush) begin
            ex_valid_d = 1'b0;
        end else if (load_en && bus.id_valid && !hazard) begin
            ex_valid_d      = 1'b1;
            ex_d.pc         = bus.id_pc;
            ex_d.rs1_val    = rs1_fwd;
            ex_d.rs2_val    = rs2_fwd;
            ex_d.imm        = bus.id_imm;
            ex_d.ctrl       = bus.id_ctrl;
            ex_d.rd_addr    = bus.id_rd_addr;
            ex_d.mem_read   = bus.id_mem_read;
            ex_d.reg_write  = bus.id_reg_write;
        end else if (load_en) begin
            // Bubble; payload left as-is since ex_valid masks it
            ex_valid_d = 1'b0;
        end
    end

    // Saturating stall counter; only hazard stalls count, not backpressure
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.stall_cnt_clr) begin
            stall_cnt_d = '0;
        end else if (bus.id_valid && hazard && !bus.flush &&
                     (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_valid_q  <= ex_valid_d;
            ex_q        <= ex_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.id_ready     = load_en && !hazard && !bus.flush;
    assign bus.ex_valid     = ex_valid_q;
    assign bus.ex_pc        = ex_q.pc;
    assign bus.ex_rs1_val   = ex_q.rs1_val;
    assign bus.ex_rs2_val   = ex_q.rs2_val;
    assign bus.ex_imm       = ex_q.imm;
    assign bus.ex_ctrl      = ex_q.ctrl;
    assign bus.ex_rd_addr   = ex_q.rd_addr;
    assign bus.ex_mem_read  = ex_q.mem_read;
    assign bus.ex_reg_write = ex_q.reg_write;
    assign bus.stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vectors with literal expectations, plus a per-cycle
// comparison against a behavioural model of the stage. A second instance with a 4-bit
// stall counter shares the stimulus to exercise saturation.
module tb_id_ex_stage;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    id_ex_stage_if #(.WIDTH(32), .CTRL_W(16), .CNT_W(16)) bus ();
    id_ex_stage_if #(.WIDTH(32), .CTRL_W(16), .CNT_W(4))  bus_s ();

    id_ex_stage #(.WIDTH(32), .CTRL_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus));
    id_ex_stage #(.WIDTH(32), .CTRL_W(16), .CNT_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(bus_s));

    assign bus_s.id_valid      = bus.id_valid;
    assign bus_s.id_pc         = bus.id_pc;
    assign bus_s.id_rs1_addr   = bus.id_rs1_addr;
    assign bus_s.id_rs2_addr   = bus.id_rs2_addr;
    assign bus_s.id_uses_rs1   = bus.id_uses_rs1;
    assign bus_s.id_uses_rs2   = bus.id_uses_rs2;
    assign bus_s.id_rs1_data   = bus.id_rs1_data;
    assign bus_s.id_rs2_data   = bus.id_rs2_data;
    assign bus_s.id_rd_addr    = bus.id_rd_addr;
    assign bus_s.id_imm        = bus.id_imm;
    assign bus_s.id_ctrl       = bus.id_ctrl;
    assign bus_s.id_mem_read   = bus.id_mem_read;
    assign bus_s.id_reg_write  = bus.id_reg_write;
    assign bus_s.flush         = bus.flush;
    assign bus_s.mem_reg_write = bus.mem_reg_write;
    assign bus_s.mem_mem_read  = bus.mem_mem_read;
    assign bus_s.mem_rd_addr   = bus.mem_rd_addr;
    assign bus_s.mem_result    = bus.mem_result;
    assign bus_s.wb_reg_write  = bus.wb_reg_write;
    assign bus_s.wb_rd_addr    = bus.wb_rd_addr;
    assign bus_s.wb_data       = bus.wb_data;
    assign bus_s.ex_ready      = bus.ex_ready;
    assign bus_s.stall_cnt_clr = bus.stall_cnt_clr;

    // ---------------- behavioural model ----------------
    bit          m_valid;
    logic [31:0] m_pc, m_rs1, m_rs2, m_imm;
    logic [15:0] m_ctrl;
    logic [4:0]  m_rd;
    bit          m_mr, m_rw;
    int          m_cnt, m_cnt_s;

    function automatic logic [31:0] m_operand(input logic [4:0] a, input logic [31:0] rf);
        if (a == 0) return 32'h0;
        if (bus.mem_reg_write && bus.mem_rd_addr == a) return bus.mem_result;
        if (bus.wb_reg_write && bus.wb_rd_addr == a) return bus.wb_data;
        return rf;
    endfunction

    // A source is blocked while the load producing it sits in EX or MEM
    function automatic bit m_blocked(input bit used, input logic [4:0] a);
        if (!used || a == 0) return 0;
        if (m_valid && m_mr && m_rw && m_rd == a) return 1;
        if (bus.mem_reg_write && bus.mem_mem_read && bus.mem_rd_addr == a) return 1;
        return 0;
    endfunction

    function automatic bit m_hazard();
        return m_blocked(bus.id_uses_rs1, bus.id_rs1_addr) ||
               m_blocked(bus.id_uses_rs2, bus.id_rs2_addr);
    endfunction

    function automatic bit m_ready();
        return (!m_valid || bus.ex_ready) && !m_hazard() && !bus.flush;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0;
            m_ctrl = 0; m_rd = 0; m_mr = 0; m_rw = 0; m_cnt = 0; m_cnt_s = 0;
        end else begin
            bit hz, room;
            hz   = m_hazard();
            room = !m_valid || bus.ex_ready;
            if (bus.stall_cnt_clr) begin
                m_cnt = 0; m_cnt_s = 0;
            end else if (bus.id_valid && hz && !bus.flush) begin
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
                if (m_cnt_s < 15) m_cnt_s = m_cnt_s + 1;
            end
            if (bus.flush) begin
                m_valid = 0;
            end else if (room && bus.id_valid && !hz) begin
                m_valid = 1;
                m_pc    = bus.id_pc;
                m_rs1   = m_operand(bus.id_rs1_addr, bus.id_rs1_data);
                m_rs2   = m_operand(bus.id_rs2_addr, bus.id_rs2_data);
                m_imm   = bus.id_imm;
                m_ctrl  = bus.id_ctrl;
                m_rd    = bus.id_rd_addr;
                m_mr    = bus.id_mem_read;
                m_rw    = bus.id_reg_write;
            end else if (room) begin
                m_valid = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("cyc ex_valid", 64'(bus.ex_valid), 64'(m_valid));
        chk("cyc ex_valid_s", 64'(bus_s.ex_valid), 64'(m_valid));
        chk("cyc id_ready", 64'(bus.id_ready), 64'(m_ready()));
        chk("cyc stall_count", 64'(bus.stall_count), 64'(m_cnt));
        chk("cyc stall_count_s", 64'(bus_s.stall_count), 64'(m_cnt_s));
        if (m_valid) begin
            chk("cyc ex_pc", 64'(bus.ex_pc), 64'(m_pc));
            chk("cyc ex_rs1_val", 64'(bus.ex_rs1_val), 64'(m_rs1));
            chk("cyc ex_rs2_val", 64'(bus.ex_rs2_val), 64'(m_rs2));
            chk("cyc ex_imm", 64'(bus.ex_imm), 64'(m_imm));
            chk("cyc ex_ctrl", 64'(bus.ex_ctrl), 64'(m_ctrl));
            chk("cyc ex_rd_addr", 64'(bus.ex_rd_addr), 64'(m_rd));
            chk("cyc ex_mem_read", 64'(bus.ex_mem_read), 64'(m_mr));
            chk("cyc ex_reg_write", 64'(bus.ex_reg_write), 64'(m_rw));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [4:0] a1, input logic [4:0] a2,
                         input bit u1, input bit u2, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [4:0] rd, input bit mr,
                         input bit rw);
        bus.id_valid     = 1'b1;
        bus.id_pc        = pc;
        bus.id_rs1_addr  = a1;
        bus.id_rs2_addr  = a2;
        bus.id_uses_rs1  = u1;
        bus.id_uses_rs2  = u2;
        bus.id_rs1_data  = d1;
        bus.id_rs2_data  = d2;
        bus.id_rd_addr   = rd;
        bus.id_imm       = pc ^ 32'h0000_5A5A;
        bus.id_ctrl      = pc[15:0] ^ 16'hC3C3;
        bus.id_mem_read  = mr;
        bus.id_reg_write = rw;
    endtask

    task automatic set_mem(input bit we, input bit ld, input logic [4:0] rd,
                           input logic [31:0] val);
        bus.mem_reg_write = we;
        bus.mem_mem_read  = ld;
        bus.mem_rd_addr   = rd;
        bus.mem_result    = val;
    endtask

    task automatic set_wb(input bit we, input logic [4:0] rd, input logic [31:0] val);
        bus.wb_reg_write = we;
        bus.wb_rd_addr   = rd;
        bus.wb_data      = val;
    endtask

    initial begin
        offer(32'h0, 5'd0, 5'd0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 0);
        bus.id_valid      = 1'b0;
        bus.flush         = 1'b0;
        bus.ex_ready      = 1'b1;
        bus.stall_cnt_clr = 1'b0;
        set_mem(0, 0, 5'd0, 32'h0);
        set_wb(0, 5'd0, 32'h0);

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("reset ex_valid", 64'(bus.ex_valid), 64'd0);
        chk("reset ex_pc", 64'(bus.ex_pc), 64'd0);
        chk("reset ex_rs1_val", 64'(bus.ex_rs1_val), 64'd0);
        chk("reset ex_ctrl", 64'(bus.ex_ctrl), 64'd0);
        chk("reset stall_count", 64'(bus.stall_count), 64'd0);
        #9 rst_n = 1'b1;
        tick();

        // Bypass priority: MEM over WB over register file, x0 always zero
        offer(32'h100, 5'd5, 5'd5, 1, 1, 32'h1111, 32'h2222, 5'd1, 0, 1);
        set_mem(1, 0, 5'd5, 32'hAAAA);
        set_wb(1, 5'd5, 32'hBBBB);
        tick();
        chk("bypass mem rs1", 64'(bus.ex_rs1_val), 64'hAAAA);
        chk("bypass mem rs2", 64'(bus.ex_rs2_val), 64'hAAAA);
        chk("bypass pc", 64'(bus.ex_pc), 64'h100);
        offer(32'h104, 5'd5, 5'd5, 1, 1, 32'h1111, 32'h2222, 5'd1, 0, 1);
        bus.mem_reg_write = 1'b0;
        tick();
        chk("bypass wb rs1", 64'(bus.ex_rs1_val), 64'hBBBB);
        offer(32'h108, 5'd5, 5'd5, 1, 1, 32'h1111, 32'h2222, 5'd1, 0, 1);
        bus.wb_reg_write = 1'b0;
        tick();
        chk("bypass rf rs1", 64'(bus.ex_rs1_val), 64'h1111);
        chk("bypass rf rs2", 64'(bus.ex_rs2_val), 64'h2222);
        offer(32'h10C, 5'd0, 5'd5, 1, 1, 32'h1111, 32'h2222, 5'd1, 0, 1);
        set_mem(1, 0, 5'd0, 32'hAAAA);
        set_wb(1, 5'd0, 32'hBBBB);
        tick();
        chk("bypass x0 rs1", 64'(bus.ex_rs1_val), 64'h0);
        set_mem(0, 0, 5'd0, 32'h0);
        set_wb(0, 5'd0, 32'h0);
        bus.id_valid = 1'b0;
        bus.stall_cnt_clr = 1'b1;
        tick();
        bus.stall_cnt_clr = 1'b0;
        chk("clr stall_count", 64'(bus.stall_count), 64'd0);

        // Load-use: two bubbles, operand then arrives from WB
        offer(32'h200, 5'd0, 5'd0, 0, 0, 32'h0, 32'h0, 5'd7, 1, 1);
        tick();
        chk("load in ex", 64'(bus.ex_mem_read), 64'd1);
        offer(32'h204, 5'd0, 5'd7, 0, 1, 32'h0, 32'hDEAD, 5'd8, 0, 1);
        #1 chk("lu ready c1", 64'(bus.id_ready), 64'd0);
        tick();
        chk("lu bubble1", 64'(bus.ex_valid), 64'd0);
        set_mem(1, 1, 5'd7, 32'h0);
        #1 chk("lu ready c2", 64'(bus.id_ready), 64'd0);
        tick();
        chk("lu bubble2", 64'(bus.ex_valid), 64'd0);
        set_mem(0, 0, 5'd0, 32'h0);
        set_wb(1, 5'd7, 32'hCAFE);
        #1 chk("lu ready c3", 64'(bus.id_ready), 64'd1);
        tick();
        chk("lu capture valid", 64'(bus.ex_valid), 64'd1);
        chk("lu rs2 from wb", 64'(bus.ex_rs2_val), 64'hCAFE);
        chk("lu stall_count", 64'(bus.stall_count), 64'd2);
        set_wb(0, 5'd0, 32'h0);

        // Backpressure: payload frozen, then next instruction taken on release edge
        offer(32'h300, 5'd1, 5'd2, 1, 1, 32'h31, 32'h32, 5'd3, 0, 1);
        tick();
        bus.ex_ready = 1'b0;
        offer(32'h304, 5'd1, 5'd2, 1, 1, 32'h41, 32'h42, 5'd4, 0, 1);
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp id_ready", 64'(bus.id_ready), 64'd0);
            tick();
            chk("bp pc held", 64'(bus.ex_pc), 64'h300);
            chk("bp rs1 held", 64'(bus.ex_rs1_val), 64'h31);
        end
        bus.ex_ready = 1'b1;
        tick();
        chk("bp release pc", 64'(bus.ex_pc), 64'h304);

        // Flush while backpressured: drop held instruction, capture nothing
        bus.ex_ready = 1'b0;
        bus.flush    = 1'b1;
        offer(32'h308, 5'd0, 5'd0, 0, 0, 32'h0, 32'h0, 5'd5, 0, 1);
        #1 chk("flush id_ready", 64'(bus.id_ready), 64'd0);
        tick();
        chk("flush ex_valid", 64'(bus.ex_valid), 64'd0);
        chk("flush no capture", 64'(bus.ex_pc), 64'h304);
        bus.flush    = 1'b0;
        bus.ex_ready = 1'b1;
        bus.id_valid = 1'b0;
        tick();

        // Asynchronous reset in the middle of a load-use stall
        offer(32'h400, 5'd0, 5'd0, 0, 0, 32'h0, 32'h0, 5'd7, 1, 1);
        tick();
        bus.ex_ready = 1'b0;
        offer(32'h404, 5'd7, 5'd0, 1, 0, 32'h0, 32'h0, 5'd9, 0, 1);
        tick();
        tick();
        chk("stall before reset", 64'(bus.stall_count), 64'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst ex_valid", 64'(bus.ex_valid), 64'd0);
        chk("async rst stall", 64'(bus.stall_count), 64'd0);
        bus.ex_ready = 1'b1;
        offer(32'h500, 5'd0, 5'd0, 0, 0, 32'h0, 32'h0, 5'd2, 0, 1);
        #2 rst_n = 1'b1;
        tick();
        chk("post rst valid", 64'(bus.ex_valid), 64'd1);
        chk("post rst pc", 64'(bus.ex_pc), 64'h500);

        // Saturation: 20 hazard cycles on the 4-bit counter
        offer(32'h600, 5'd0, 5'd0, 0, 0, 32'h0, 32'h0, 5'd7, 1, 1);
        tick();
        bus.ex_ready = 1'b0;
        offer(32'h604, 5'd7, 5'd0, 1, 0, 32'h0, 32'h0, 5'd9, 0, 1);
        repeat (20) tick();
        chk("sat cnt4", 64'(bus_s.stall_count), 64'd15);
        chk("sat cnt16", 64'(bus.stall_count), 64'd20);
        bus.stall_cnt_clr = 1'b1;
        tick();
        chk("sat clr cnt4", 64'(bus_s.stall_count), 64'd0);
        chk("sat clr cnt16", 64'(bus.stall_count), 64'd0);
        bus.stall_cnt_clr = 1'b0;
        bus.id_valid      = 1'b0;
        bus.ex_ready      = 1'b1;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
